// File: rtl/cpu_perf_monitor_pkg.sv
// Shared definitions for the CPU performance monitor: FSM states, CSR word offsets, control bits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_perf_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Word offsets inside the 64-word counter window
  localparam int OFF_CYC     = 0;
  localparam int OFF_INSTRET = 1;
  localparam int OFF_EVT0    = 2;
  localparam int OFF_TRACE0  = 32;
  localparam int OFF_TFILL   = 61;
  localparam int OFF_STATUS  = 62;
  localparam int OFF_CTRL    = 63;

  // Control register bit positions
  localparam int CTRL_CLR_BIT = 0;
  localparam int CTRL_FRZ_BIT = 1;

endpackage

// File: rtl/cpu_perf_monitor_perf_counter.sv
// Single free-running event counter with synchronous clear, freeze and sticky wrap flag.
// Latency: count visible one enabled cycle after the increment request.
// Backpressure: none; en_i low holds all state.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             frz_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Clear wins over increment; wrap flag sets when the all-ones value rolls to zero.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (clr_i) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (inc_i && !frz_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (&cnt_q) wrap_d = 1'b1;
    end
  end

  // Counter state register, updated only on enabled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (en_i) begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/cpu_perf_monitor.sv
// Cycle/instret/event counters with a CSR read window and halt-on-write exit path.
// Latency: CSR read data returned with o_rvalid one enabled cycle after i_drd; halt two enabled cycles after the write.
// Backpressure: none; i_clk_en low freezes everything. Optional PC trace buffer under CPU_PERF_TRACE_FIFO_EN.
module cpu_perf_monitor #(
  parameter int              ADDR_W      = 24,
  parameter int              DATA_W      = 32,
  parameter int              CNT_W       = 32,
  parameter int              NEVT        = 4,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(24'hFFFFFF),
  parameter logic [ADDR_W-1:0] CSR_BASE  = ADDR_W'(24'hFFFF00),
  parameter int              TRACE_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_retire,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [NEVT-1:0]   i_evt,
  input  logic [ADDR_W-1:0] i_daddr,
  input  logic              i_dwr,
  input  logic              i_drd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_halt,
  output logic [7:0]        o_halt_code,
  output logic [NEVT+1:0]   o_ovf
);
  import cpu_perf_monitor_pkg::*;

  localparam int NCNT = 2 + NEVT;

  state_e            state_q, state_d;
  logic [7:0]        code_q, code_d;
  logic              frz_q, frz_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_val, trace_rd;
  logic              rvalid_q, rvalid_d;

  logic              csr_hit, ctrl_wr, clr, halt_req, cnt_frz;
  logic [5:0]        off;
  logic [NCNT-1:0]   inc, wrap;
  logic [CNT_W-1:0]  cnt [NCNT];

  assign csr_hit  = (i_daddr[ADDR_W-1:6] == CSR_BASE[ADDR_W-1:6]);
  assign off      = i_daddr[5:0];
  assign ctrl_wr  = i_dwr && csr_hit && (off == 6'(OFF_CTRL));
  assign clr      = ctrl_wr && i_wdata[CTRL_CLR_BIT];
  assign halt_req = i_dwr && (i_daddr == HALT_ADDR);
  assign cnt_frz  = frz_q || (state_q == ST_HALTED);

  // Per-counter increment requests: cycle always, instret on retire, events per bit.
  always_comb begin
    inc               = {i_evt, 2'b00};
    inc[OFF_CYC]      = 1'b1;
    inc[OFF_INSTRET]  = i_retire;
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .en_i   (i_clk_en),
      .inc_i  (inc[g]),
      .clr_i  (clr),
      .frz_i  (cnt_frz),
      .cnt_o  (cnt[g]),
      .wrap_o (wrap[g])
    );
  end

  // Halt FSM: the halting write moves to DRAIN so that cycle's retire and events still count.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_DRAIN;
          code_d  = i_wdata[7:0];
        end
      end
      ST_DRAIN: state_d = ST_HALTED;
      default:  state_d = state_q;
    endcase
  end

  // CSR read mux; sees pre-update register values so same-cycle writes return old data.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (off == 6'(OFF_CYC + k)) rd_val = DATA_W'(cnt[k]);
    end
    if (off >= 6'(OFF_TRACE0) && off <= 6'(OFF_TFILL)) rd_val = trace_rd;
    if (off == 6'(OFF_STATUS))  rd_val = DATA_W'({wrap, code_q, state_q});
    if (off == 6'(OFF_CTRL))    rd_val = DATA_W'({frz_q, 1'b0});
  end

  // Read response and freeze-bit next state.
  always_comb begin
    rvalid_d = i_drd && csr_hit;
    rdata_d  = rvalid_d ? rd_val : rdata_q;
    frz_d    = ctrl_wr ? i_wdata[CTRL_FRZ_BIT] : frz_q;
  end

  // Control and response registers; reset returns to RUN from any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RUN;
      code_q   <= '0;
      frz_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (i_clk_en) begin
      state_q  <= state_d;
      code_q   <= code_d;
      frz_q    <= frz_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef CPU_PERF_TRACE_FIFO_EN
  localparam int TW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [ADDR_W-1:0] trace_q [TRACE_DEPTH];
  logic [TW-1:0]     wptr_q, wptr_d, t_idx;
  logic [TW:0]       fill_q, fill_d;
  logic [5:0]        t_rel;
  logic              trace_cap;

  assign trace_cap = i_retire && (state_q != ST_HALTED) && !clr;

  // Write pointer wraps; fill count saturates so a full buffer overwrites its oldest entry.
  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (clr) begin
      wptr_d = '0;
      fill_d = '0;
    end else if (trace_cap) begin
      wptr_d = wptr_q + TW'(1);
      if (fill_q != (TW+1)'(TRACE_DEPTH)) fill_d = fill_q + (TW+1)'(1);
    end
  end

  // Trace pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else if (i_clk_en) begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
    end
  end

  // Trace storage; contents need no reset because the fill count gates every read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_clk_en && trace_cap) trace_q[wptr_q] <= i_pc;
  end

  // Oldest-first view: entry 0 is the oldest PC still held.
  always_comb begin
    t_rel    = off - 6'(OFF_TRACE0);
    t_idx    = wptr_q - fill_q[TW-1:0] + t_rel[TW-1:0];
    trace_rd = '0;
    if (off == 6'(OFF_TFILL)) begin
      trace_rd = DATA_W'(fill_q);
    end else if (off >= 6'(OFF_TRACE0) && int'(t_rel) < int'(fill_q)) begin
      trace_rd = DATA_W'(trace_q[t_idx]);
    end
  end
`else
  assign trace_rd = '0;

  logic unused_pc;
  assign unused_pc = ^i_pc;
`endif

  logic unused_wdata;
  assign unused_wdata = ^i_wdata[DATA_W-1:8];

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_halt      = (state_q == ST_HALTED);
  assign o_halt_code = code_q;
  assign o_ovf       = wrap;

endmodule
